// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with write bypass, busy scoreboard and sequenced clear-on-reset
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_wren,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  input  logic              i_rsv_valid,
  output logic              o_rsv_ready,
  output logic              o_init_done
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic              w_run, w_wr_ok, w_rsv_ok, w_hit1, w_hit2, w_z1, w_z2, w_zwr, w_zrsv;
  assign w_run    = r_state == S_RUN;
  assign w_z1     = (ZERO_REG != 0) && (i_rs1_addr == '0);
  assign w_z2     = (ZERO_REG != 0) && (i_rs2_addr == '0);
  assign w_zwr    = (ZERO_REG != 0) && (i_wr_addr == '0);
  assign w_zrsv   = (ZERO_REG != 0) && (i_rsv_addr == '0);
  assign w_wr_ok  = w_run && i_wr_wren && !w_zwr;
  assign w_hit1   = w_wr_ok && (i_wr_addr == i_rs1_addr);
  assign w_hit2   = w_wr_ok && (i_wr_addr == i_rs2_addr);
  assign w_rsv_ok = o_rsv_ready && !w_zrsv;
  // state register and clear counter; reset restarts the sweep at entry 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == S_INIT) ? r_cnt + ADDR_W'(1) : '0;
    end
  end
  // leave INIT on the edge that clears the last entry
  always_comb w_state_nxt = (r_state == S_INIT && r_cnt == '1) ? S_RUN : r_state;
  // read muxes, busy flags and reservation handshake; all quiet until RUN
  always_comb begin
    o_init_done = w_run;
    o_rs1_data  = (!w_run || w_z1) ? '0 : (BYPASS != 0 && w_hit1) ? i_wr_data : r_mem[i_rs1_addr];
    o_rs2_data  = (!w_run || w_z2) ? '0 : (BYPASS != 0 && w_hit2) ? i_wr_data : r_mem[i_rs2_addr];
    o_rs1_busy  = w_run && !w_z1 && !w_hit1 && r_busy[i_rs1_addr];
    o_rs2_busy  = w_run && !w_z2 && !w_hit2 && r_busy[i_rs2_addr];
    o_rsv_ready = w_run && i_rsv_valid && (!r_busy[i_rsv_addr] || (i_wr_wren && i_wr_addr == i_rsv_addr));
  end
  // INIT clears one entry per cycle; in RUN the reservation is applied after the write so it wins
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (!w_run) begin
        r_mem[r_cnt]  <= '0;
        r_busy[r_cnt] <= 1'b0;
      end else begin
        if (w_wr_ok) begin
          r_mem[i_wr_addr]  <= i_wr_data;
          r_busy[i_wr_addr] <= 1'b0;
        end
        if (w_rsv_ok) r_busy[i_rsv_addr] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed bench comparing bypass and non-bypass instances against a behavioural model
module tb_regfile_scoreboard;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, wa = '0, ra = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0, rv = 1'b0;
  logic [31:0] d1a, d1b, d0a, d0b;
  logic        b1a, b1b, b0a, b0b, r1, r0, dn1, dn0;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] m_data [32];
  bit          m_busy [32];
  int          m_left = 0;
  bit          m_valid = 1'b0;

  always #5 i_clk = ~i_clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_b1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .o_rs1_data(d1a), .o_rs2_data(d1b), .o_rs1_busy(b1a), .o_rs2_busy(b1b),
    .i_wr_addr(wa), .i_wr_data(wd), .i_wr_wren(we), .i_rsv_addr(ra),
    .i_rsv_valid(rv), .o_rsv_ready(r1), .o_init_done(dn1));

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_b0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .o_rs1_data(d0a), .o_rs2_data(d0b), .o_rs1_busy(b0a), .o_rs2_busy(b0b),
    .i_wr_addr(wa), .i_wr_data(wd), .i_wr_wren(we), .i_rsv_addr(ra),
    .i_rsv_valid(rv), .o_rsv_ready(r0), .o_init_done(dn0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_run();
    return m_left == 0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!m_run() || a == 0) return 32'h0;
    if (byp && we && wa == a) return wd;
    return m_data[a];
  endfunction

  function automatic logic exp_bz(input logic [4:0] a);
    if (!m_run() || a == 0 || (we && wa == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_ready();
    return m_run() && rv && (!m_busy[ra] || (we && wa == ra));
  endfunction

  // reset wipes everything at once and then counts down the 32 INIT cycles
  always @(posedge i_clk) begin
    bit rdy;
    rdy = exp_ready();
    if (i_rst) begin
      m_valid = 1'b1;
      m_left  = 32;
      for (int i = 0; i < 32; i++) begin
        m_data[i] = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      if (we && wa != 0) begin
        m_data[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (rdy && ra != 0) m_busy[ra] = 1'b1;
    end
  end

  always @(negedge i_clk) begin
    if (m_valid) begin
      chk("b1_rs1_data", d1a, exp_rd(rs1, 1'b1));
      chk("b1_rs2_data", d1b, exp_rd(rs2, 1'b1));
      chk("b0_rs1_data", d0a, exp_rd(rs1, 1'b0));
      chk("b0_rs2_data", d0b, exp_rd(rs2, 1'b0));
      chk("b1_rs1_busy", 32'(b1a), 32'(exp_bz(rs1)));
      chk("b1_rs2_busy", 32'(b1b), 32'(exp_bz(rs2)));
      chk("b0_rs1_busy", 32'(b0a), 32'(exp_bz(rs1)));
      chk("b0_rs2_busy", 32'(b0b), 32'(exp_bz(rs2)));
      chk("b1_ready", 32'(r1), 32'(exp_ready()));
      chk("b0_ready", 32'(r0), 32'(exp_ready()));
      chk("b1_done", 32'(dn1), 32'(m_run()));
      chk("b0_done", 32'(dn0), 32'(m_run()));
    end
  end

  task automatic step(input logic we_, input logic [4:0] wa_, input logic [31:0] wd_,
                      input logic rv_, input logic [4:0] ra_, input logic [4:0] r1_, input logic [4:0] r2_);
    @(posedge i_clk);
    #1;
    we = we_; wa = wa_; wd = wd_; rv = rv_; ra = ra_; rs1 = r1_; rs2 = r2_;
    @(negedge i_clk);
  endtask

  task automatic wait_init(input bit poke, output int n);
    n = 0;
    if (poke) begin
      we = 1'b1; wa = 5'd9; wd = 32'h99; rv = 1'b1; ra = 5'd9; rs1 = 5'd9;
    end
    for (int c = 0; c < 100; c++) begin
      if (poke && c == 5) begin
        #1;
        we = 1'b0; rv = 1'b0;
      end
      @(negedge i_clk);
      if (dn1) break;
      n++;
      if (poke && c < 5) begin
        chk("init_ready_b1", 32'(r1), 32'h0);
        chk("init_ready_b0", 32'(r0), 32'h0);
        chk("init_data", d1a, 32'h0);
      end
    end
  endtask

  task automatic pulse_rst();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    wait_init(1'b0, n);
    chk("init_len_first", n, 32);
    step(1, 5'd3, 32'hA5A5A5A5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 5'd3, 0);
    chk("x3_written", d1a, 32'hA5A5A5A5);
    pulse_rst();
    wait_init(1'b0, n);
    chk("init_len_pulse", n, 32);
    chk("x3_cleared", d1a, 32'h0);
    for (int a = 0; a < 32; a++) begin
      step(0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      chk("busy_clear_b1", 32'(b1a), 32'h0);
      chk("busy_clear_b0", 32'(b0b), 32'h0);
    end
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 5'd5, 0);
    chk("x5_b1", d1a, 32'hDEADBEEF);
    chk("x5_b0", d0a, 32'hDEADBEEF);
    step(1, 5'd5, 32'h12345678, 0, 0, 0, 5'd5);
    chk("x5_bypass", d1b, 32'h12345678);
    chk("x5_nobypass", d0b, 32'hDEADBEEF);
    step(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 0);
    chk("x0_rsv_ready", 32'(r1), 32'h1);
    step(0, 0, 0, 0, 0, 5'd0, 0);
    chk("x0_data_b1", d1a, 32'h0);
    chk("x0_data_b0", d0a, 32'h0);
    chk("x0_busy", 32'(b1a), 32'h0);
    step(0, 0, 0, 1, 5'd7, 5'd7, 0);
    chk("x7_rsv_ready", 32'(r1), 32'h1);
    chk("x7_not_busy_yet", 32'(b1a), 32'h0);
    step(0, 0, 0, 1, 5'd7, 5'd7, 0);
    chk("x7_busy", 32'(b1a), 32'h1);
    chk("x7_rsv_refused", 32'(r1), 32'h0);
    step(1, 5'd7, 32'h11, 0, 0, 5'd7, 0);
    chk("x7_wr_busy_fwd", 32'(b1a), 32'h0);
    chk("x7_wr_bypass", d1a, 32'h11);
    chk("x7_wr_nobypass", d0a, 32'h0);
    step(0, 0, 0, 0, 0, 5'd7, 0);
    chk("x7_retired_busy", 32'(b0a), 32'h0);
    chk("x7_retired_data", d0a, 32'h11);
    step(0, 0, 0, 1, 5'd7, 5'd7, 0);
    chk("x7_rsv_again", 32'(r1), 32'h1);
    step(1, 5'd7, 32'h22, 1, 5'd7, 5'd7, 0);
    chk("x7_wr_rsv_ready_b1", 32'(r1), 32'h1);
    chk("x7_wr_rsv_ready_b0", 32'(r0), 32'h1);
    step(0, 0, 0, 0, 0, 5'd7, 0);
    chk("x7_wr_rsv_data", d0a, 32'h22);
    chk("x7_wr_rsv_busy_b1", 32'(b1a), 32'h1);
    chk("x7_wr_rsv_busy_b0", 32'(b0a), 32'h1);
    pulse_rst();
    repeat (10) @(posedge i_clk);
    #1;
    pulse_rst();
    wait_init(1'b1, n);
    chk("init_len_restart", n, 32);
    step(0, 0, 0, 0, 0, 5'd9, 5'd7);
    chk("x9_untouched_b0", d0a, 32'h0);
    chk("x9_not_busy", 32'(b0a), 32'h0);
    chk("x7_busy_cleared", 32'(b1b), 32'h0);
    chk("x7_data_cleared", d1b, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
